// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and byte-lane helpers for the data memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_load;
    logic   err;
  } resp_t;

  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] we;
    case (size)
      SZ_B:    we = 4'b0001 << addr_lo;
      SZ_H:    we = 4'b0011 << addr_lo;
      SZ_W:    we = 4'b1111;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  // Narrow stores are replicated so the enabled lanes always see the right bytes.
  function automatic logic [31:0] lane_wd(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] wd;
    case (size)
      SZ_B:    wd = {4{wdata[7:0]}};
      SZ_H:    wd = {2{wdata[15:0]}};
      SZ_W:    wd = wdata;
      default: wd = 32'h0;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/dmem_store_fmt.sv
// rtl/dmem_store_fmt.sv - combinational lane formatting and access check for the granted request
module dmem_store_fmt
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
  input  logic        gnt,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_we,
  output logic        err
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned   = ((size == SZ_H) && addr[0]) ||
                   ((size == SZ_W) && (addr[1:0] != 2'b00));
    out_of_range = (addr >= ADDR_LIMIT);
    err          = gnt && (misaligned || out_of_range || (size == SZ_X));
  end

  // A rejected store is still consumed, but must never touch the RAM.
  always_comb begin
    mem_a  = 32'h0;
    mem_wd = 32'h0;
    mem_we = 4'b0000;
    if (gnt) begin
      mem_a = {addr[31:2], 2'b00};
      if (we) begin
        mem_wd = lane_wd(size, wdata);
        if (!err) begin
          mem_we = lane_we(size, addr[1:0]);
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-master arbiter for DataRam port A with starvation guard
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic        sel_m1;
  logic        win_gnt;
  logic        win_we;
  logic [1:0]  win_size;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        fmt_err;
  resp_t       resp;
  logic        rsp_live;
  logic [31:0] rsp_data;

  // m0 has priority; m1 only wins a contended cycle once it has waited STARVE_MAX cycles.
  always_comb begin
    sel_m1  = m1_req && (!m0_req || (starve_cnt == STARVE_LIM));
    win_gnt = rst_n && (m0_req || m1_req);
    m0_gnt  = rst_n && m0_req && !sel_m1;
    m1_gnt  = rst_n && sel_m1;
  end

  always_comb begin
    win_we    = sel_m1 ? m1_we    : m0_we;
    win_size  = sel_m1 ? m1_size  : m0_size;
    win_addr  = sel_m1 ? m1_addr  : m0_addr;
    win_wdata = sel_m1 ? m1_wdata : m0_wdata;
  end

  dmem_store_fmt #(
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_fmt (
    .gnt    (win_gnt),
    .we     (win_we),
    .size   (win_size),
    .addr   (win_addr),
    .wdata  (win_wdata),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_we (mem_we),
    .err    (fmt_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (m1_req && !m1_gnt) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Single response stage; its owner field doubles as the last-winner record.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp <= '{valid: 1'b0, owner: OWN_M0, is_load: 1'b0, err: 1'b0};
    end else begin
      resp <= '{valid:   win_gnt,
                owner:   sel_m1 ? OWN_M1 : OWN_M0,
                is_load: !win_we,
                err:     fmt_err};
    end
  end

  always_comb begin
    rsp_live  = rst_n && resp.valid;
    rsp_data  = (resp.is_load && !resp.err) ? mem_rd : 32'h0;
    m0_rvalid = rsp_live && (resp.owner == OWN_M0);
    m1_rvalid = rsp_live && (resp.owner == OWN_M1);
    m0_err    = m0_rvalid && resp.err;
    m1_err    = m1_rvalid && resp.err;
    m0_rdata  = m0_rvalid ? rsp_data : 32'h0;
    m1_rdata  = m1_rvalid ? rsp_data : 32'h0;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares DataRam port A (synchronous BRAM, word-addressed, 1-cycle read latency, 4-bit byte write enable) between two requesters: m0 = CPU load/store unit, m1 = debug/DMA master.
- Arbitrates the two requesters and accepts requests back-to-back.
- Formats store data into byte lanes, generates the byte write enables and returns the raw read word.
- Load extension remains in DataExt downstream.

Parameters:
- STARVE_MAX, 4, cycles m1 may wait while m0 keeps winning before m1 is forced a grant (1..15).
- ADDR_LIMIT, 32'h0000_4000, byte address bound; accesses at or above it are rejected with err.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- m0_req  in  1  m0 request valid
- m0_we  in  1  1 = store, 0 = load
- m0_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- m0_addr  in  32  byte address
- m0_wdata  in  32  store data, right-aligned
- m0_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid  out  1  response valid, one cycle after gnt
- m0_rdata  out  32  raw BRAM word (valid with rvalid on loads, 0 on stores)
- m0_err  out  1  misaligned, illegal size or out of range (qualified by rvalid)
- m1_*  same set as m0_*
- mem_a  out  32  to DataSeg A; word-aligned, low 2 bits are 0
- mem_wd  out  32  lane-shifted store data
- mem_we  out  4  byte write enables
- mem_rd  in  32  DataSeg RD

Behaviour:
- Reset (rst_n=0 at a clk edge) state:
  - all rvalid, err and rdata = 0
  - starve counter = 0
  - last-winner = m0
  - a response pending at reset is discarded, not delivered after reset
- Gnt, mem_a, mem_wd and mem_we are combinational. They are forced to 0 whenever rst_n=0.
- Arbitration, evaluated each cycle. At most one gnt per cycle.
  - Only one requester asserts req: it is granted.
  - Both assert req: m0 wins unless starve_cnt == STARVE_MAX, in which case m1 wins.
- starve_cnt:
  - increments when m1_req=1 and m1 is not granted
  - clears when m1 is granted or m1_req=0
  - saturates at STARVE_MAX
- Granted request drives mem_a = {addr[31:2], 2'b00}.
- Store lane rules (mem_we, mem_wd):
  - byte: mem_we = 4'b0001 << addr[1:0]; wdata[7:0] replicated to all 4 lanes
  - half: mem_we = 4'b0011 << addr[1:0]; wdata[15:0] replicated to both halves
  - word: mem_we = 4'b1111; mem_wd = wdata
  - loads: mem_we = 0
  - no grant: mem_we = 0, mem_a = 0, mem_wd = 0
- Errors: half with addr[0]=1, word with addr[1:0]!=0, size=11, or addr >= ADDR_LIMIT.
  - The request is still granted (consumed).
  - mem_we is forced to 0.
  - Next cycle: rvalid=1, err=1, rdata=0.
- Response pipeline:
  - One register stage holds {valid, owner, is_load, err}.
  - Cycle N+1 after a gnt: owner's rvalid=1 for exactly one cycle.
  - rdata = mem_rd if load and not err, else 0.
- Throughput: one grant per cycle. Back-to-back and alternating owners are supported.
- Ordering: responses return in grant order.
- Requester contract: addr, we, size and wdata stay stable while req=1 and gnt=0.
- Load after store to the same word in consecutive cycles returns the new data (BRAM write precedes read in the next cycle).

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W
  - owner encoding OWN_M0/OWN_M1
  - function lane_we(size, addr_lo)
  - function lane_wd(size, wdata)
- One sub-module, dmem_store_fmt: combinational lane formatting and error check, instantiated once on the muxed winner.

Test Plan:
- Reset mid-op: m0 load gnt at cycle N, rst_n=0 at N+1 -> m0_rvalid stays 0; all outputs 0 during reset.
- m0 store, word 32'hDEADBEEF @0x10, then m0 load @0x10 next cycle -> mem_we=1111 on the store; m0_rvalid=1 with m0_rdata=32'hDEADBEEF one cycle after the load gnt.
- m0 store, byte 8'hA5 @0x13 -> mem_a=0x10, mem_we=1000, mem_wd=32'hA5A5A5A5; subsequent word load of 0x10 shows only byte 3 changed.
- m1 half store @0x21 -> gnt, mem_we=0000; next cycle m1_rvalid=1, m1_err=1; memory unchanged. Repeat with addr 0x4000 -> err.
- m0 and m1 requesting continuously, STARVE_MAX=4 -> m1 granted on the 5th contended cycle, then m0 for the next 4; responses arrive in order with the correct owners.
- Alternating m0/m1 loads every cycle -> one gnt per cycle, each rvalid exactly one cycle later, no dropped or duplicated responses.
